if_stage: RTL and testbench

- Instruction-fetch stage for the pipelined successor of the single-cycle MIPS datapath.
- Owns the PC register and the IF/ID pipeline register, and drives the instruction-memory read address.
- Feeds the decode stage with a registered instruction, PC, PC+8 and fetch-exception flag.
- Takes stall/flush from the hazard unit and the delayed-branch redirect from decode.

---
 rtl/mips_pkg.sv | 7 +
 rtl/if_id_reg.sv | 41 ++++
 rtl/if_stage.sv | 34 +++
 tb/tb_if_stage.sv | 114 +++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: constants shared by the pipelined MIPS fetch path
package mips_pkg;
  localparam logic [31:0] NOP_INSTR    = 32'h0;
  localparam logic [4:0]  EXC_ADEL     = 5'd4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] PC_STEP      = 32'd4;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with stall/flush priority, fetch-exception detect and fetch counter
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int          IM_DEPTH = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] f_pc,
  input  logic [31:0] imem_rdata,
  output logic [31:0] d_instr,
  output logic [31:0] d_pc,
  output logic [31:0] d_pc8,
  output logic        d_valid,
  output logic        d_exc,
  output logic [31:0] fetch_cnt
);
  localparam logic [32:0] IM_END = {1'b0, IM_BASE} + 33'(IM_DEPTH) * 33'd4;
  logic w_exc;
  assign w_exc = (|f_pc[1:0]) || (f_pc < IM_BASE) || ({1'b0, f_pc} >= IM_END);
  always_ff @(posedge clk) begin
    if (reset) begin
      d_instr   <= NOP_INSTR;
      d_pc      <= '0;
      d_pc8     <= '0;
      d_valid   <= 1'b0;
      d_exc     <= 1'b0;
      fetch_cnt <= '0;
    end else if (!stall) begin
      d_pc      <= f_pc;
      d_pc8     <= f_pc + 32'd8;
      d_valid   <= !flush;
      d_exc     <= !flush && w_exc;
      d_instr   <= (flush || w_exc) ? NOP_INSTR : imem_rdata;
      fetch_cnt <= flush ? fetch_cnt : fetch_cnt + 32'd1;
    end
  end
endmodule

// File: rtl/if_stage.sv
// if_stage: MIPS instruction fetch with PC register, next-PC mux and IF/ID register
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int          IM_DEPTH = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] f_pc,
  output logic [31:0] d_instr,
  output logic [31:0] d_pc,
  output logic [31:0] d_pc8,
  output logic        d_valid,
  output logic        d_exc,
  output logic [31:0] fetch_cnt
);
  assign imem_addr = f_pc;
  always_ff @(posedge clk)
    f_pc <= reset ? RESET_PC : stall ? f_pc : redirect ? redirect_pc : f_pc + PC_STEP;
  if_id_reg #(.IM_BASE(IM_BASE), .IM_DEPTH(IM_DEPTH)) u_if_id (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .f_pc(f_pc), .imem_rdata(imem_rdata),
    .d_instr(d_instr), .d_pc(d_pc), .d_pc8(d_pc8),
    .d_valid(d_valid), .d_exc(d_exc), .fetch_cnt(fetch_cnt)
  );
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: scoreboard bench for if_stage against a rule-level fetch model
module tb_if_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b0, stall = 1'b0, flush = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr, imem_rdata, f_pc, d_instr, d_pc, d_pc8, fetch_cnt;
  logic        d_valid, d_exc;
  typedef struct packed {
    logic [31:0] pc, instr, dpc, dpc8, cnt;
    logic        v, e;
  } exp_t;
  exp_t q[$];
  int tests = 0, fails = 0;
  logic [31:0] m_pc, m_instr, m_dpc, m_dpc8, m_cnt;
  logic        m_v, m_e;
  bit          done = 1'b0;
  always #5 clk = ~clk;
  assign imem_rdata = 32'h2400_0000 + ((imem_addr - 32'h3000) >> 2);
  if_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .f_pc(f_pc),
    .d_instr(d_instr), .d_pc(d_pc), .d_pc8(d_pc8),
    .d_valid(d_valid), .d_exc(d_exc), .fetch_cnt(fetch_cnt)
  );
  function automatic logic [31:0] im_word(input logic [31:0] a);
    return 32'h2400_0000 + ((a - 32'h3000) / 4);
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", n, act, exp, $time);
    end
  endtask
  task automatic cycle(input logic r, input logic s, input logic fl, input logic rd, input logic [31:0] rpc);
    bit bad;
    @(negedge clk);
    reset = r; stall = s; flush = fl; redirect = rd; redirect_pc = rpc;
    if (r) begin
      m_pc = 32'h3000; m_instr = 0; m_dpc = 0; m_dpc8 = 0; m_v = 0; m_e = 0; m_cnt = 0;
    end else if (!s) begin
      bad = (m_pc % 4 != 0) || (m_pc < 32'h3000) || (m_pc >= 32'h3000 + 4 * 4096);
      m_dpc = m_pc; m_dpc8 = m_pc + 8;
      if (fl) begin
        m_instr = 0; m_v = 0; m_e = 0;
      end else begin
        m_instr = bad ? 0 : im_word(m_pc); m_v = 1; m_e = bad; m_cnt = m_cnt + 1;
      end
      m_pc = rd ? rpc : m_pc + 4;
    end
    q.push_back('{m_pc, m_instr, m_dpc, m_dpc8, m_cnt, m_v, m_e});
    @(posedge clk);
  endtask
  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        x = q.pop_front();
        chk("f_pc", f_pc, x.pc);
        chk("imem_addr", imem_addr, x.pc);
        chk("d_instr", d_instr, x.instr);
        chk("d_pc", d_pc, x.dpc);
        chk("d_pc8", d_pc8, x.dpc8);
        chk("d_valid", {31'b0, d_valid}, {31'b0, x.v});
        chk("d_exc", {31'b0, d_exc}, {31'b0, x.e});
        chk("fetch_cnt", fetch_cnt, x.cnt);
      end
    end
  end
  initial begin
    logic [31:0] rpc;
    cycle(1, 0, 0, 0, 0);
    repeat (4) cycle(0, 0, 0, 0, 0);
    repeat (3) cycle(0, 1, 0, 0, 0);
    repeat (2) cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    repeat (2) cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 32'h3100);
    repeat (2) cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 1, 1, 32'h3200);
    cycle(0, 0, 0, 1, 32'h3200);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 32'h3102);
    repeat (2) cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 32'h0000_2ffc);
    repeat (3) cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 32'h6ffc);
    repeat (2) cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 32'hffff_fffc);
    repeat (3) cycle(0, 0, 0, 0, 0);
    cycle(1, 1, 1, 1, 32'h5000);
    repeat (2) cycle(0, 0, 0, 0, 0);
    repeat (500) begin
      case ($urandom_range(0, 3))
        0: rpc = $urandom;
        1: rpc = 32'h3000 + ($urandom_range(0, 4200) << 2) + $urandom_range(0, 3);
        default: rpc = 32'h3000 + ($urandom_range(0, 4095) << 2);
      endcase
      cycle($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, rpc);
    end
    @(negedge clk);
    reset = 0; stall = 0; flush = 0; redirect = 0;
    @(posedge clk);
    #2;
    chk("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
